lms_tdm_core: RTL and testbench
===============================

# lms_tdm_core

Parametrised, time-multiplexed LMS adaptive FIR core for the noise-cancellation datapath. It replaces the fixed-order wrapper with one shared MAC: it walks the taps serially and computes the error internally from the sample's own desired value. It supports selectable adaptation modes, a shift-based step size, weight freeze/clear and full saturation. It sits between the sample source (reference `xin`, desired `din`) and the noise-removal output stage.

## Interface
- `X_W`, 16, reference sample width, signed Q1.(X_W-1)
- `D_W`, 16, desired/output width, signed
- `W_W`, 16, weight width, signed Q1.(W_W-1)
- `E_W`, 16, error width, signed
- `ORDER`, 16, number of taps (≥2)
- `ACC_W`, 40, MAC accumulator width
- `MU_MAX`, 15, largest legal `mu_shift`
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  sample offered
- `in_ready`  out  1  core accepts sample this cycle
- `xin`  in  X_W  reference sample
- `din`  in  D_W  desired sample paired with `xin`
- `mu_shift`  in  4  step size 2^-mu_shift
- `mode`  in  2  0 LMS, 1 sign-error, 2 sign-sign, 3 no-adapt
- `freeze`  in  1  skip weight update for this sample
- `w_clr`  in  1  clear all weights (honoured only in IDLE)
- `out_valid`  out  1  one-cycle pulse, `yout`/`err` valid
- `yout`  out  D_W  filter output, registered
- `err`  out  E_W  din − yout, saturated, registered
- `wout`  out  W_W*ORDER  all weights, tap 0 in LSBs
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM: IDLE → FILTER → ERR → UPDATE → IDLE. Reset state is IDLE.
- `in_ready` = (state==IDLE) & !`w_clr`.
- On accept, the delay line shifts: x[0]←`xin`, x[k]←x[k-1]. `din` is captured into d_r.
- FILTER runs ORDER cycles with tap index k=0..ORDER-1. Each cycle: acc += w[k]*x[k]. acc is cleared on accept.
- ERR runs 1 cycle:
  - y = sat_D_W(acc >>> (W_W-1)).
  - e = sat_E_W(d_r − y).
  - Register `yout`, `err`, and assert `out_valid`.
  - Latch `mode` and `mu_shift`; clamp `mu_shift` to MU_MAX.
  - If `freeze` or mode 3, go to IDLE; else go to UPDATE.
- UPDATE runs ORDER cycles, k=0..ORDER-1: w[k] ← sat_W_W(w[k] + Δk).
  - mode 0: Δ = (e*x[k]) >>> (X_W-1+mu).
  - mode 1: Δ = sign(e)·x[k] >>> mu. Δ=0 when e=0.
  - mode 2: Δ = sign(e)·sign(x[k])·2^(W_W-2-mu), minimum magnitude 1. Δ=0 when e=0 or x[k]=0.
- All shifts are arithmetic. All saturation clamps to [−2^(n-1), 2^(n-1)−1]. Nothing wraps.
- `w_clr` in IDLE zeroes all weights in one cycle. The delay line is kept. `w_clr` outside IDLE is ignored.
- Inputs other than `freeze`/`mode`/`mu_shift` are ignored when not in IDLE.

## Timing
- Reset values:
  - all weights, delay line, acc, d_r, `yout`, `err` = 0
  - `out_valid` = 0, `busy` = 0
  - `in_ready` = 1 (when `w_clr`=0)
- Accept at cycle T:
  - FILTER occupies T+1..T+ORDER.
  - ERR occupies T+ORDER+1.
  - `out_valid` pulses at T+ORDER+2.
- With adaptation: UPDATE occupies T+ORDER+2..T+2·ORDER+1, and `in_ready` returns at T+2·ORDER+2.
- Frozen (`freeze` or mode 3): `in_ready` returns at T+ORDER+2.
- `wout` changes during UPDATE one tap per cycle and is stable whenever `in_ready`=1.
- `rst_n` low mid-operation aborts immediately. All state returns to reset values.

## Structure
- Package `lms_pkg`:
  - state enum
  - mode constants LMS/SIGN_ERR/SIGN_SIGN/NO_ADAPT
  - generic saturate function
- Sub-module `lms_sat`: parametrised in/out width signed saturator, instantiated for y, e and weight paths.
- One shared multiplier, used by FILTER and mode-0 UPDATE.

## Test plan
- Reset: hold `rst_n` low with random inputs → `wout`=0, `yout`=0, `err`=0, `out_valid`=0, `in_ready`=1.
- Mode-0 step: weights 0, accept `xin`=0x4000, `din`=0x2000, `mu_shift`=0 at T → `out_valid` at T+18 with `yout`=0, `err`=0x2000; w[0]=0x1000, others 0; `in_ready` at T+34.
- Error saturation: preload all w=0x7FFF via repeated training, `xin` stream 0x8000, `din`=0x7FFF → `err`=0x7FFF, not wrapped. Weight overflow clamps at 0x7FFF/0x8000.
- Sign-sign: mode 2, `mu_shift`=4, e>0, x[0]<0, x[1]=0 → w[0] decreases by 0x0400, w[1] unchanged.
- Freeze/no-adapt: `freeze`=1 at ERR → `wout` unchanged, `in_ready` at T+18. Repeat with mode 3 → same result.
- Clear and abort: `w_clr` in IDLE → `wout`=0 next cycle, `in_ready`=0 that cycle. `w_clr` during UPDATE → ignored. `rst_n` pulse during FILTER → IDLE, all zero, next sample accepted normally.

Source files
------------

// File: rtl/lms_pkg.sv
// Shared types, mode encodings and the saturation helper for the LMS core.
package lms_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILTER = 2'd1,
    S_ERR    = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LMS       = 2'd0;
  localparam logic [1:0] MODE_SIGN_ERR  = 2'd1;
  localparam logic [1:0] MODE_SIGN_SIGN = 2'd2;
  localparam logic [1:0] MODE_NO_ADAPT  = 2'd3;

  // Clamp a signed value to the range of an n-bit signed number (n <= 64).
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int n);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/lms_tdm_core_if.sv
// Sample-in / result-out handshake bundle of the LMS core.
interface lms_tdm_core_if #(
  parameter int X_W = 16,
  parameter int D_W = 16,
  parameter int E_W = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [X_W-1:0] xin;
  logic [D_W-1:0] din;
  logic           out_valid;
  logic [D_W-1:0] yout;
  logic [E_W-1:0] err;

  modport master (output in_valid, xin, din, input in_ready, out_valid, yout, err);
  modport slave  (input in_valid, xin, din, output in_ready, out_valid, yout, err);
endinterface

// File: rtl/lms_sat.sv
// Width-reducing signed saturator: clamps IN_W-bit a into OUT_W bits.
module lms_sat
  import lms_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  a,
  output logic signed [OUT_W-1:0] y
);
  assign y = OUT_W'(sat(64'(a), OUT_W));
endmodule

// File: rtl/lms_tdm_core.sv
// Time-multiplexed LMS adaptive FIR: one shared MAC walks the taps for the
// filter pass and again for the weight-update pass.
module lms_tdm_core
  import lms_pkg::*;
#(
  parameter int X_W    = 16,
  parameter int D_W    = 16,
  parameter int W_W    = 16,
  parameter int E_W    = 16,
  parameter int ORDER  = 16,
  parameter int ACC_W  = 40,
  parameter int MU_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lms_tdm_core_if.slave          bus,
  input  logic [3:0]             mu_shift,
  input  logic [1:0]             mode,
  input  logic                   freeze,
  input  logic                   w_clr,
  output logic [W_W*ORDER-1:0]   wout,
  output logic                   busy
);
  localparam int KW   = $clog2(ORDER);
  localparam int MW   = (W_W > E_W) ? W_W : E_W;  // shared multiplier operand A
  localparam int P_W  = MW + X_W;                 // full product
  localparam int DL_W = P_W + 1;                  // delta (room for -min)
  localparam int SW   = DL_W + 1;                 // weight + delta
  localparam int DF_W = D_W + 1;                  // d - y

  state_t state_q, state_d;
  logic [KW-1:0]                 k_q;
  logic [ORDER-1:0][X_W-1:0]     x_q;
  logic [ORDER-1:0][W_W-1:0]     w_q;
  logic signed [ACC_W-1:0]       acc_q;
  logic signed [D_W-1:0]         d_r;
  logic signed [D_W-1:0]         yout_q;
  logic signed [E_W-1:0]         err_q;
  logic                          out_valid_q;
  logic [1:0]                    mode_r;
  logic [3:0]                    mu_r;

  logic accept, do_clr, last_k;
  logic signed [X_W-1:0]  x_k;
  logic signed [W_W-1:0]  w_k, w_new;
  logic signed [MW-1:0]   mul_a;
  logic signed [P_W-1:0]  prod;
  logic signed [D_W-1:0]  y_sat;
  logic signed [E_W-1:0]  e_sat;
  logic signed [DF_W-1:0] diff;
  logic signed [DL_W-1:0] delta, prod_x, xs, sx, mag;
  logic signed [SW-1:0]   w_sum;
  logic                   e_neg, e_zero, x_zero;

  assign last_k = (k_q == KW'(ORDER - 1));
  assign x_k    = x_q[k_q];
  assign w_k    = w_q[k_q];
  assign wout   = w_q;

  assign bus.out_valid = out_valid_q;
  assign bus.yout      = yout_q;
  assign bus.err       = err_q;

  // The one multiplier: w[k]*x[k] while filtering, e*x[k] while updating.
  assign mul_a = (state_q == S_UPDATE) ? MW'(err_q) : MW'(w_k);
  assign prod  = P_W'(mul_a) * P_W'(x_k);

  // Output and error saturation.
  lms_sat #(.IN_W(ACC_W), .OUT_W(D_W)) u_sat_y (.a(acc_q >>> (W_W - 1)), .y(y_sat));
  assign diff = DF_W'(d_r) - DF_W'(y_sat);
  lms_sat #(.IN_W(DF_W), .OUT_W(E_W)) u_sat_e (.a(diff), .y(e_sat));

  assign e_neg  = err_q[E_W-1];
  assign e_zero = (err_q == '0);
  assign x_zero = (x_k == '0);

  // Per-tap weight increment for the latched adaptation mode.
  always_comb begin
    delta  = '0;
    prod_x = DL_W'(prod);
    xs     = DL_W'(x_k);
    sx     = e_neg ? -xs : xs;
    mag    = '0;
    if (int'(mu_r) > W_W - 2) mag[0] = 1'b1;
    else                      mag    = DL_W'(1) <<< (W_W - 2 - int'(mu_r));
    case (mode_r)
      MODE_LMS:       delta = prod_x >>> ((X_W - 1) + int'(mu_r));
      MODE_SIGN_ERR:  if (!e_zero) delta = sx >>> mu_r;
      MODE_SIGN_SIGN: if (!e_zero && !x_zero) delta = (e_neg ^ x_k[X_W-1]) ? -mag : mag;
      default:        delta = '0;
    endcase
  end

  assign w_sum = SW'(w_k) + SW'(delta);
  lms_sat #(.IN_W(SW), .OUT_W(W_W)) u_sat_w (.a(w_sum), .y(w_new));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: freeze and mode are looked at in ERR to skip the update pass.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.in_valid && !w_clr) state_d = S_FILTER;
      S_FILTER: if (last_k) state_d = S_ERR;
      S_ERR:    state_d = (freeze || mode == MODE_NO_ADAPT) ? S_IDLE : S_UPDATE;
      S_UPDATE: if (last_k) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshake, clear strobe, busy.
  always_comb begin
    bus.in_ready = (state_q == S_IDLE) && !w_clr;
    accept       = (state_q == S_IDLE) && !w_clr && bus.in_valid;
    do_clr       = (state_q == S_IDLE) && w_clr;
    busy         = (state_q != S_IDLE);
  end

  // Datapath: delay line, accumulator, result registers, weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q         <= '0;
      x_q         <= '0;
      w_q         <= '0;
      acc_q       <= '0;
      d_r         <= '0;
      yout_q      <= '0;
      err_q       <= '0;
      out_valid_q <= 1'b0;
      mode_r      <= MODE_LMS;
      mu_r        <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (accept) begin
        x_q   <= {x_q[ORDER-2:0], bus.xin};
        d_r   <= bus.din;
        acc_q <= '0;
        k_q   <= '0;
      end
      if (do_clr) w_q <= '0;
      case (state_q)
        S_FILTER: begin
          acc_q <= acc_q + ACC_W'(prod);
          k_q   <= last_k ? '0 : k_q + KW'(1);
        end
        S_ERR: begin
          yout_q      <= y_sat;
          err_q       <= e_sat;
          out_valid_q <= 1'b1;
          mode_r      <= mode;
          mu_r        <= (int'(mu_shift) > MU_MAX) ? 4'(MU_MAX) : mu_shift;
          k_q         <= '0;
        end
        S_UPDATE: begin
          w_q[k_q] <= w_new;
          k_q      <= last_k ? '0 : k_q + KW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_tdm_core.sv
// Scoreboard bench for lms_tdm_core: an arithmetic reference model predicts
// each result and the weight vector; a monitor checks results as they appear.
module tb_lms_tdm_core;
  localparam int ORDER = 16;
  localparam int NW    = 16 * ORDER;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] mu_shift = '0;
  logic [1:0] mode = '0;
  logic freeze = 1'b0;
  logic w_clr = 1'b0;
  logic [NW-1:0] wout;
  logic busy;

  lms_tdm_core_if #(.X_W(16), .D_W(16), .E_W(16)) bus ();

  lms_tdm_core #(.X_W(16), .D_W(16), .W_W(16), .E_W(16), .ORDER(ORDER),
                 .ACC_W(40), .MU_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .mu_shift(mu_shift), .mode(mode),
    .freeze(freeze), .w_clr(w_clr), .wout(wout), .busy(busy));

  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- reference model ----------------
  longint mw[ORDER];
  longint mx[ORDER];

  typedef struct { logic [15:0] y; logic [15:0] e; int cyc; } exp_t;
  exp_t exp_q[$];

  function automatic longint msat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint sgn(input longint v);
    return (v > 0) ? 1 : (v < 0) ? -1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ORDER; k++) begin mw[k] = 0; mx[k] = 0; end
  endtask

  function automatic logic [511:0] model_w();
    logic [511:0] v = '0;
    for (int k = 0; k < ORDER; k++) v[k*16 +: 16] = 16'(mw[k]);
    return v;
  endfunction

  // Filter, error and (optional) adaptation for one sample, as plain arithmetic.
  task automatic model_step(input logic [15:0] x, input logic [15:0] d, input logic [3:0] mu,
                            input logic [1:0] md, input logic frz, input int out_cyc);
    longint acc, y, e, dl;
    exp_t ex;
    int m;
    for (int k = ORDER - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = longint'($signed(x));
    acc = 0;
    for (int k = 0; k < ORDER; k++) acc += mw[k] * mx[k];
    y = msat(acc >>> 15);
    e = msat(longint'($signed(d)) - y);
    ex.y = 16'(y); ex.e = 16'(e); ex.cyc = out_cyc;
    exp_q.push_back(ex);
    if (frz || md == 2'd3) return;
    m = (int'(mu) > 15) ? 15 : int'(mu);
    for (int k = 0; k < ORDER; k++) begin
      case (md)
        2'd0: dl = (e * mx[k]) >>> (15 + m);
        2'd1: dl = (sgn(e) * mx[k]) >>> m;
        default: dl = sgn(e) * sgn(mx[k]) * ((m > 14) ? 1 : (longint'(1) << (14 - m)));
      endcase
      mw[k] = msat(mw[k] + dl);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t ex;
        ex = exp_q.pop_front();
        chk("yout", bus.yout, ex.y);
        chk("err", bus.err, ex.e);
        chk("out_valid_cycle", pcyc, ex.cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] d, input logic [3:0] mu,
                      input logic [1:0] md, input logic frz, input bit clr_mid);
    int n, lat;
    wait_ready();
    bus.in_valid = 1'b1; bus.xin = x; bus.din = d;
    mu_shift = mu; mode = md; freeze = frz;
    model_step(x, d, mu, md, frz, pcyc + ORDER + 2);
    lat = (frz || md == 2'd3) ? ORDER + 2 : 2 * ORDER + 2;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.xin = 16'($urandom); bus.din = 16'($urandom);
    n = 1;
    while (!bus.in_ready && n < 3 * ORDER + 10) begin
      if (clr_mid && n == ORDER + 5) w_clr = 1'b1;
      if (clr_mid && n == ORDER + 8) w_clr = 1'b0;
      @(negedge clk); n++;
    end
    chk("ready_latency", n, lat);
    chk("wout", wout, model_w());
  endtask

  task automatic clear_w();
    wait_ready();
    w_clr = 1'b1;
    #1 chk("clr_in_ready_low", bus.in_ready, 0);
    @(negedge clk);
    for (int k = 0; k < ORDER; k++) mw[k] = 0;
    chk("clr_wout", wout, model_w());
    w_clr = 1'b0;
  endtask

  initial begin
    logic [NW-1:0] vec;
    bus.in_valid = 1'b0; bus.xin = '0; bus.din = '0;
    model_reset();

    // reset held with random inputs
    repeat (5) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom); bus.xin = 16'($urandom); bus.din = 16'($urandom);
      mu_shift = 4'($urandom); mode = 2'($urandom); freeze = 1'($urandom);
    end
    #1;
    chk("rst_wout", wout, 0);
    chk("rst_yout", bus.yout, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // mode-0 single step: w[0] becomes 0x1000
    send(16'h4000, 16'h2000, 4'd0, 2'd0, 1'b0, 1'b0);
    vec = '0; vec[15:0] = 16'h1000;
    chk("m0_w0_literal", wout, vec);

    // clear, then sign-sign with x[0]<0, x[1]=0, e>0
    clear_w();
    send(16'h0000, 16'h0000, 4'd0, 2'd0, 1'b1, 1'b0);
    send(16'hFF00, 16'h1000, 4'd4, 2'd2, 1'b0, 1'b0);
    chk("ss_w0_literal", wout[15:0], 16'hFC00);
    chk("ss_w1_literal", wout[31:16], 16'h0000);

    // freeze and no-adapt keep the weights
    send(16'($urandom), 16'($urandom), 4'd3, 2'd0, 1'b1, 1'b0);
    send(16'($urandom), 16'($urandom), 4'd3, 2'd3, 1'b0, 1'b0);

    // w_clr during UPDATE is ignored
    send(16'h3000, 16'h1000, 4'd2, 2'd0, 1'b0, 1'b1);

    // saturation: drive all weights to 0x7FFF, then error and weight clamps
    clear_w();
    repeat (ORDER) send(16'h7FFF, 16'h0000, 4'd0, 2'd0, 1'b1, 1'b0);
    send(16'h7FFF, 16'h7FFF, 4'd0, 2'd1, 1'b0, 1'b0);
    chk("sat_all_7fff", wout, {ORDER{16'h7FFF}});
    repeat (ORDER) send(16'h8000, 16'h7FFF, 4'd0, 2'd0, 1'b1, 1'b0);
    repeat (2) send(16'h8000, 16'h7FFF, 4'd0, 2'd1, 1'b0, 1'b0);
    chk("sat_all_8000", wout, {ORDER{16'h8000}});
    repeat (2) send(16'h8000, 16'h8000, 4'd0, 2'd1, 1'b0, 1'b0);
    chk("sat_back_7fff", wout, {ORDER{16'h7FFF}});

    // abort with reset pulse during FILTER
    wait_ready();
    bus.in_valid = 1'b1; bus.xin = 16'h1234; bus.din = 16'h4321; mode = 2'd0; freeze = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    chk("abort_wout", wout, 0);
    chk("abort_yout", bus.yout, 0);
    chk("abort_err", bus.err, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'h4000, 16'h2000, 4'd0, 2'd0, 1'b0, 1'b0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) clear_w();
      send(16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // absolute guard so the run always terminates
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
